// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the serial sequence detector: words in on valid/ready,
// one bit per clock out on x_out. Optional trailing even-parity bit under `SERIAL_PARITY_EN.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SERIAL_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             init_q;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             frame_done_q, frame_done_d;
`ifdef SERIAL_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             ready_c;
  logic             accept_c;

  // Window in which a new word may be taken; gated until the first edge out of reset.
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      ST_IDLE:   ready_c = 1'b1;
`ifdef SERIAL_PARITY_EN
      ST_SHIFT:  ready_c = 1'b0;
      ST_PARITY: ready_c = 1'b1;
`else
      ST_SHIFT:  ready_c = (bit_cnt_q == '0);
`endif
      default:   ready_c = 1'b0;
    endcase
  end

  assign in_ready = init_q & ready_c;
  assign accept_c = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    x_out_d      = IDLE_BIT;
    x_valid_d    = 1'b0;
    frame_done_d = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_d        = par_q;
`endif
    if (accept_c) begin
      // First bit goes straight to x_out; sr keeps the rest, aligned at the exit end.
      state_d   = ST_SHIFT;
      bit_cnt_d = CNT_LAST;
      x_valid_d = 1'b1;
      if (MSB_FIRST != 0) begin
        x_out_d = in_data[WIDTH-1];
        sr_d    = in_data << 1;
      end else begin
        x_out_d = in_data[0];
        sr_d    = in_data >> 1;
      end
`ifdef SERIAL_PARITY_EN
      par_d = ^in_data;
`endif
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            x_valid_d = 1'b1;
            if (MSB_FIRST != 0) begin
              x_out_d = sr_q[WIDTH-1];
              sr_d    = sr_q << 1;
            end else begin
              x_out_d = sr_q[0];
              sr_d    = sr_q >> 1;
            end
`ifndef SERIAL_PARITY_EN
            frame_done_d = (bit_cnt_q == CNT_W'(1));
`endif
          end else begin
`ifdef SERIAL_PARITY_EN
            state_d      = ST_PARITY;
            x_out_d      = par_q;
            x_valid_d    = 1'b1;
            frame_done_d = 1'b1;
`else
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef SERIAL_PARITY_EN
        ST_PARITY: state_d = ST_IDLE;
`endif
        ST_IDLE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      init_q       <= 1'b0;
      x_out_q      <= IDLE_BIT;
      x_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      init_q       <= 1'b1;
      x_out_q      <= x_out_d;
      x_valid_q    <= x_valid_d;
      frame_done_q <= frame_done_d;
`ifdef SERIAL_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign x_out      = x_out_q;
  assign x_valid    = x_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = x_valid_q;

endmodule
